alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Upstream command stage for the 8-bit ALU.
- Accepts operation commands (opcode plus two operands) over a valid/ready handshake and buffers them in a 2-entry queue.
- Drives the ALU's X, Y and S inputs with stable registered values, then samples the combinational result Z after a programmable settle time.
- Presents the captured result downstream over a second valid/ready handshake.
- An accumulator register lets a command reuse the previous result as its X operand.

Parameters:
- SETTLE_CYCLES, 1: clock edges between driving X/Y/S and sampling Z. Legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear: flush the queue, drop any op in flight, zero the accumulator.
- in_valid  in  1  command valid.
- in_ready  out  1  command queue not full.
- in_op  in  3  ALU select code, passed to S.
- in_a  in  8  X operand.
- in_b  in  8  Y operand.
- in_use_acc  in  1  when 1, X is the accumulator and in_a is ignored.
- X  out  8  to ALU X.
- Y  out  8  to ALU Y.
- S  out  3  to ALU S.
- Z  in  8  from ALU Z.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_result  out  8  captured Z.
- out_op  out  3  opcode that produced out_result.
- busy  out  1  high when state is not IDLE or the queue is non-empty.

Behaviour:
- Reset (rst_n low, asynchronous): the following are all 0: X, Y, S, out_result, out_op, out_valid, accumulator, settle counter. Queue is empty, state is IDLE, busy=0, in_ready=1. Reset mid-operation discards everything in flight.
- Queue: 2-entry FIFO of {op, a, b, use_acc}.
  - in_ready = !full, with no bypass: a full queue holds in_ready=0 even in a cycle where it pops.
  - Push on in_valid && in_ready at a rising edge.
  - Push and pop in the same edge is legal when not full; count is unchanged.
- Load action (pop): at the edge where a command is popped:
  - X <= use_acc ? accumulator : a; Y <= b; S <= op; out_op <= op.
  - counter <= SETTLE_CYCLES; state -> WAIT.
  - X, Y and S then stay constant until the next load.
- States:
  - IDLE: if the queue is non-empty, do the load action.
  - WAIT: the counter decrements each edge. On the edge where the counter equals 1: out_result <= Z, accumulator <= Z, out_valid <= 1, state -> HOLD. Z is therefore sampled exactly SETTLE_CYCLES edges after the load edge.
  - HOLD: out_valid, out_result and out_op stay stable until out_valid && out_ready.
    - On that edge out_valid <= 0.
    - If the queue is non-empty, do the load action in the same edge (state -> WAIT); otherwise state -> IDLE.
- Latency and throughput:
  - Command accepted at edge T into an empty, idle block → loaded at T+1 → out_valid high after edge T+1+SETTLE_CYCLES.
  - With out_ready tied high, sustained throughput is one command per SETTLE_CYCLES+1 cycles.
- Accumulator: 8 bits. It changes only on a capture edge or on clr/reset. A use_acc command issued before any capture uses 0.
  - When use_acc is set, X is taken from the accumulator at load time, i.e. it already includes the preceding command's result.
- Width rules: X, Y and S are registered copies of the queued fields with no arithmetic performed here. Z is captured as-is (8 bits; no carry or overflow is handled here).
- clr (synchronous):
  - Takes priority over push, pop and capture in the same edge. A command presented with in_valid in the clr cycle is dropped.
  - After the edge: queue empty, state IDLE, out_valid=0, accumulator=0, counter=0.
  - X, Y, S, out_result and out_op keep their last values.
- Downstream back-pressure: with out_ready held low the block holds one result in HOLD plus two queued commands, after which in_ready=0.

Test Plan:
1. Reset release, then idle for 5 cycles → all outputs 0, in_ready=1, busy=0. Assert rst_n low mid-WAIT → out_valid=0, busy=0, X/Y/S=0 immediately, without waiting for a clock edge.
2. SETTLE_CYCLES=1, ALU model Z=X+Y when S=4; push op=4, a=0x05, b=0x03 at edge T → X=0x05, Y=0x03, S=4 after T+1; out_valid=1 and out_result=0x08 after T+2; out_op=4.
3. Accumulator chain: push {op=4, a=0x01, b=0x02} then {op=4, use_acc=1, a=0xFF, b=0x04} → results 0x03 then 0x07; the second X is 0x03, not 0xFF.
4. Back-pressure: out_ready=0, push 4 commands back-to-back → 3 accepted, in_ready=0 on the 4th attempt. Release out_ready → 3 results emerge in order; in_ready rises one cycle after the first queue pop.
5. SETTLE_CYCLES=3: the ALU model presents 0xAA until 2 edges after load, then the correct value → the captured value is the correct one, taken on the 3rd edge after load, never 0xAA.
6. Assert clr in HOLD with in_valid=1 and a queued command → out_valid=0, queue empty, the presented command is not accepted, the accumulator reads 0 on the next use_acc command.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Command and result bus for the ALU op sequencer: upstream command
// handshake, the ALU X/Y/S/Z connection, the downstream result handshake
// and the busy status flag.
interface alu_op_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_use_acc;
  logic [7:0] X;
  logic [7:0] Y;
  logic [2:0] S;
  logic [7:0] Z;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [2:0] out_op;
  logic       busy;

  // Sequencer side
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_use_acc, Z, out_ready,
    output in_ready, X, Y, S, out_valid, out_result, out_op, busy
  );

  // Command source / ALU / result sink side
  modport master (
    output in_valid, in_op, in_a, in_b, in_use_acc, Z, out_ready,
    input  in_ready, X, Y, S, out_valid, out_result, out_op, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: buffers commands in a 2-entry queue, drives the ALU
// operands from registers, samples Z after SETTLE_CYCLES edges and offers
// the result downstream. The accumulator holds the last captured result.
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input logic               clk,
  input logic               rst_n,
  input logic               clr,
  alu_op_sequencer_if.slave bus
);
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t            state, state_nxt;
  logic [2:0]        q_op  [2];
  logic [DATA_W-1:0] q_a   [2];
  logic [DATA_W-1:0] q_b   [2];
  logic              q_acc [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] acc;
  logic              full, empty, push, load, capture, hand_off;

  // No bypass: a full queue refuses input even while it is being popped.
  assign full         = (count == 2'd2);
  assign empty        = (count == 2'd0);
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full && !clr;
  assign bus.busy     = (state != IDLE) || !empty;

  // Next-state and per-edge action strobes; clr overrides everything.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    hand_off  = 1'b0;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            load      = 1'b1;
            state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (bus.out_valid && bus.out_ready) begin
            hand_off = 1'b1;
            if (!empty) begin
              load      = 1'b1;
              state_nxt = WAIT;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Queue pointers and occupancy; a load is always the pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clr) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (load) rd_ptr <= ~rd_ptr;
      case ({push, load})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_op[wr_ptr]  <= bus.in_op;
      q_a[wr_ptr]   <= bus.in_a;
      q_b[wr_ptr]   <= bus.in_b;
      q_acc[wr_ptr] <= bus.in_use_acc;
    end
  end

  // Settle counter: loaded on pop, counts down while waiting for Z.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= 4'd0;
    else if (clr)            cnt <= 4'd0;
    else if (load)           cnt <= 4'(SETTLE_CYCLES);
    else if (state == WAIT)  cnt <= cnt - 4'd1;
  end

  // ALU operand drive, result capture, accumulator and result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.X          <= '0;
      bus.Y          <= '0;
      bus.S          <= '0;
      bus.out_op     <= '0;
      bus.out_result <= '0;
      bus.out_valid  <= 1'b0;
      acc            <= '0;
    end else if (clr) begin
      bus.out_valid <= 1'b0;
      acc           <= '0;
    end else begin
      if (capture) begin
        bus.out_result <= bus.Z;
        bus.out_valid  <= 1'b1;
        acc            <= bus.Z;
      end
      if (hand_off) bus.out_valid <= 1'b0;
      if (load) begin
        bus.X      <= q_acc[rd_ptr] ? acc : q_a[rd_ptr];
        bus.Y      <= q_b[rd_ptr];
        bus.S      <= q_op[rd_ptr];
        bus.out_op <= q_op[rd_ptr];
      end
    end
  end
endmodule
